// File: rtl/shift_register_param.sv
// Parametrised universal register with clock enable, parallel load, logical or
// rotating shifts in both directions and a shift counter that saturates at WIDTH.
module shift_register_param #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  localparam int              CNT_W       = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             rotate,
  input  logic             ser_in_msb,
  input  logic             ser_in_lsb,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             ser_out_lsb,
  output logic             ser_out_msb,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             drained
);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  logic [WIDTH-1:0] q_next;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] cnt_inc;
  logic             fill;

  // Both shift directions share one counter; it stops at WIDTH.
  assign cnt_inc = (shift_cnt == CNT_MAX) ? shift_cnt : shift_cnt + 1'b1;

  always_comb begin
    q_next   = q;
    cnt_next = shift_cnt;
    fill     = 1'b0;
    if (en) begin
      case (mode)
        MODE_RIGHT: begin
          fill     = rotate ? q[0] : ser_in_msb;
          q_next   = {fill, q[WIDTH-1:1]};
          cnt_next = cnt_inc;
        end
        MODE_LEFT: begin
          fill     = rotate ? q[WIDTH-1] : ser_in_lsb;
          q_next   = {q[WIDTH-2:0], fill};
          cnt_next = cnt_inc;
        end
        MODE_LOAD: begin
          q_next   = d;
          cnt_next = '0;
        end
        MODE_HOLD: begin
          q_next   = q;
          cnt_next = shift_cnt;
        end
        default: begin
          q_next   = q;
          cnt_next = shift_cnt;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q         <= RESET_VALUE;
      shift_cnt <= '0;
    end else begin
      q         <= q_next;
      shift_cnt <= cnt_next;
    end
  end

  assign ser_out_lsb = q[0];
  assign ser_out_msb = q[WIDTH-1];
  assign drained     = (shift_cnt == CNT_MAX);

endmodule
